// File: rtl/rsa_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rsa_pkg : shared types and defaults for the RSA job sequencer        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package rsa_pkg;

  localparam int DEFAULT_WIDTH          = 128;
  localparam int DEFAULT_TIMEOUT_CYCLES = 65535;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_INV_PULSE = 3'd1,
    ST_INV_WAIT  = 3'd2,
    ST_EXP_PULSE = 3'd3,
    ST_EXP_WAIT  = 3'd4,
    ST_RESP      = 3'd5
  } state_e;

endpackage
`default_nettype wire

// File: rtl/rsa_key_cache.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rsa_key_cache : remembers the key of the last completed inverter run |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module rsa_key_cache
  import rsa_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             store_i,
  input  logic             invalidate_i,
  input  logic [WIDTH-1:0] st_p_i,
  input  logic [WIDTH-1:0] st_q_i,
  input  logic             st_ed_i,
  input  logic [WIDTH-1:0] lk_p_i,
  input  logic [WIDTH-1:0] lk_q_i,
  input  logic             lk_ed_i,
  output logic             hit_o
);

  logic [WIDTH-1:0] key_p_q;
  logic [WIDTH-1:0] key_q_q;
  logic             key_ed_q;
  logic             key_valid_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      key_p_q     <= '0;
      key_q_q     <= '0;
      key_ed_q    <= 1'b0;
      key_valid_q <= 1'b0;
    end else if (invalidate_i) begin
      key_valid_q <= 1'b0;
    end else if (store_i) begin
      key_p_q     <= st_p_i;
      key_q_q     <= st_q_i;
      key_ed_q    <= st_ed_i;
      key_valid_q <= 1'b1;
    end
  end

  assign hit_o = key_valid_q && (lk_p_i == key_p_q) && (lk_q_i == key_q_q)
                 && (lk_ed_i == key_ed_q);

endmodule
`default_nettype wire

// File: rtl/rsa_job_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rsa_job_sequencer : drives the RSA control core through inverter and |
// | mod_exp phases for one request/response job at a time. Rev 1.0       |
// +----------------------------------------------------------------------+
module rsa_job_sequencer
  import rsa_pkg::*;
#(
  parameter int WIDTH          = DEFAULT_WIDTH,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [WIDTH-1:0]   req_p,
  input  logic [WIDTH-1:0]   req_q,
  input  logic               req_encrypt_decrypt,
  input  logic [2*WIDTH-1:0] req_msg,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [2*WIDTH-1:0] resp_msg,
  output logic               resp_error,
  output logic               busy,
  output logic [WIDTH-1:0]   core_p,
  output logic [WIDTH-1:0]   core_q,
  output logic               core_encrypt_decrypt,
  output logic [2*WIDTH-1:0] core_msg_in,
  output logic               core_reset_inverter,
  output logic               core_reset_mod_exp,
  input  logic               core_inverter_finish,
  input  logic               core_mod_exp_finish,
  input  logic [2*WIDTH-1:0] core_msg_out
);

  localparam int             CNT_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   p_q, p_d, q_q, q_d;
  logic               ed_q, ed_d;
  logic [2*WIDTH-1:0] msg_q, msg_d;
  logic [2*WIDTH-1:0] resp_msg_q, resp_msg_d;
  logic               resp_error_q, resp_error_d;
  logic               key_store, key_inval, key_hit;

  rsa_key_cache #(.WIDTH(WIDTH)) u_key_cache (
    .clk          (clk),
    .reset_n      (reset_n),
    .store_i      (key_store),
    .invalidate_i (key_inval),
    .st_p_i       (p_q),
    .st_q_i       (q_q),
    .st_ed_i      (ed_q),
    .lk_p_i       (req_p),
    .lk_q_i       (req_q),
    .lk_ed_i      (req_encrypt_decrypt),
    .hit_o        (key_hit)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q        <= '0;
      p_q          <= '0;
      q_q          <= '0;
      ed_q         <= 1'b0;
      msg_q        <= '0;
      resp_msg_q   <= '0;
      resp_error_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      p_q          <= p_d;
      q_q          <= q_d;
      ed_q         <= ed_d;
      msg_q        <= msg_d;
      resp_msg_q   <= resp_msg_d;
      resp_error_q <= resp_error_d;
    end
  end

  // A wait cycle with cnt_q == 0 is the blank cycle: finish there may be stale.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    p_d          = p_q;
    q_d          = q_q;
    ed_d         = ed_q;
    msg_d        = msg_q;
    resp_msg_d   = resp_msg_q;
    resp_error_d = resp_error_q;
    key_store    = 1'b0;
    key_inval    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          p_d     = req_p;
          q_d     = req_q;
          ed_d    = req_encrypt_decrypt;
          msg_d   = req_msg;
          state_d = key_hit ? ST_EXP_PULSE : ST_INV_PULSE;
        end
      end
      ST_INV_PULSE: begin
        cnt_d   = '0;
        state_d = ST_INV_WAIT;
      end
      ST_INV_WAIT: begin
        if (core_inverter_finish && (cnt_q != '0)) begin
          key_store = 1'b1;
          state_d   = ST_EXP_PULSE;
        end else if (cnt_q == CNT_LAST) begin
          resp_msg_d   = '0;
          resp_error_d = 1'b1;
          key_inval    = 1'b1;
          state_d      = ST_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_EXP_PULSE: begin
        cnt_d   = '0;
        state_d = ST_EXP_WAIT;
      end
      ST_EXP_WAIT: begin
        if (core_mod_exp_finish && (cnt_q != '0)) begin
          resp_msg_d   = core_msg_out;
          resp_error_d = 1'b0;
          state_d      = ST_RESP;
        end else if (cnt_q == CNT_LAST) begin
          resp_msg_d   = '0;
          resp_error_d = 1'b1;
          key_inval    = 1'b1;
          state_d      = ST_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign req_ready            = (state_q == ST_IDLE);
  assign busy                 = (state_q != ST_IDLE);
  assign resp_valid           = (state_q == ST_RESP);
  assign resp_msg             = resp_msg_q;
  assign resp_error           = resp_error_q;
  assign core_p               = p_q;
  assign core_q               = q_q;
  assign core_encrypt_decrypt = ed_q;
  assign core_msg_in          = msg_q;
  assign core_reset_inverter  = (state_q == ST_INV_PULSE);
  assign core_reset_mod_exp   = (state_q == ST_EXP_PULSE);

endmodule
`default_nettype wire

// File: tb/tb_rsa_job_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_rsa_job_sequencer : schedule-model bench with a stub RSA core     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_rsa_job_sequencer;

  localparam int W        = 128;
  localparam int TO       = 16;
  localparam int M_NORMAL = 0;
  localparam int M_NEVER  = 1;
  localparam int M_STALE  = 2;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           req_valid = 1'b0, req_ready;
  logic [W-1:0]   req_p = '0, req_q = '0;
  logic           req_encrypt_decrypt = 1'b0;
  logic [2*W-1:0] req_msg = '0;
  logic           resp_valid, resp_ready = 1'b0;
  logic [2*W-1:0] resp_msg;
  logic           resp_error, busy;
  logic [W-1:0]   core_p, core_q;
  logic           core_encrypt_decrypt;
  logic [2*W-1:0] core_msg_in, core_msg_out;
  logic           core_reset_inverter, core_reset_mod_exp;
  logic           core_inverter_finish, core_mod_exp_finish;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int stub_mode = M_NORMAL;
  int inv_cd, exp_cd;
  bit chk_en = 1'b0;

  // Model: the job schedule predicted from the accept cycle and stub timing.
  int             jid = -1;
  int             m_t0 = -1, m_inv = -1, m_exp = -1, m_resp = -1, m_rel = -1;
  logic [2*W-1:0] m_rmsg = '0;
  logic           m_rerr = 1'b0;
  logic [W-1:0]   m_cp = '0, m_cq = '0;
  logic           m_ced = 1'b0;
  logic [2*W-1:0] m_cmsg = '0;
  bit             m_kv = 1'b0;
  logic [W-1:0]   m_kp = '0, m_kq = '0;
  logic           m_ked = 1'b0;

  int             obs_inv[12]  = '{default: -1};
  int             obs_exp[12]  = '{default: -1};
  int             obs_resp[12] = '{default: -1};
  logic [2*W-1:0] obs_msg[12];
  logic           obs_err[12];

  rsa_job_sequencer #(.WIDTH(W), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_p(req_p), .req_q(req_q), .req_encrypt_decrypt(req_encrypt_decrypt),
    .req_msg(req_msg),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_msg(resp_msg), .resp_error(resp_error), .busy(busy),
    .core_p(core_p), .core_q(core_q), .core_encrypt_decrypt(core_encrypt_decrypt),
    .core_msg_in(core_msg_in),
    .core_reset_inverter(core_reset_inverter), .core_reset_mod_exp(core_reset_mod_exp),
    .core_inverter_finish(core_inverter_finish), .core_mod_exp_finish(core_mod_exp_finish),
    .core_msg_out(core_msg_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stub core: inverter finishes 5 cycles after its pulse, mod_exp 8 after.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      inv_cd <= 0;
      exp_cd <= 0;
    end else begin
      inv_cd <= core_reset_inverter ? 5 : ((inv_cd != 0) ? inv_cd - 1 : 0);
      exp_cd <= core_reset_mod_exp  ? 8 : ((exp_cd != 0) ? exp_cd - 1 : 0);
    end
  end
  assign core_inverter_finish = (stub_mode == M_STALE) || (stub_mode == M_NORMAL && inv_cd == 1);
  assign core_mod_exp_finish  = (stub_mode == M_STALE) || (exp_cd == 1);
  assign core_msg_out         = ~core_msg_in;

  task automatic chk(input string nm, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_req_ready"}, req_ready, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_resp_valid"}, resp_valid, 0);
    chk({tag, "_resp_msg"}, resp_msg, 0);
    chk({tag, "_resp_error"}, resp_error, 0);
    chk({tag, "_core_p"}, core_p, 0);
    chk({tag, "_core_q"}, core_q, 0);
    chk({tag, "_core_ed"}, core_encrypt_decrypt, 0);
    chk({tag, "_core_msg_in"}, core_msg_in, 0);
    chk({tag, "_pulse_inv"}, core_reset_inverter, 0);
    chk({tag, "_pulse_exp"}, core_reset_mod_exp, 0);
  endtask

  // Per-cycle comparison of every output against the model schedule.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        bit be, rv;
        be = (m_t0 >= 0) && (cyc > m_t0) && (cyc <= m_rel);
        rv = (m_t0 >= 0) && (cyc >= m_resp) && (cyc <= m_rel);
        chk("req_ready", req_ready, !be);
        chk("busy", busy, be);
        chk("resp_valid", resp_valid, rv);
        chk("pulse_inv", core_reset_inverter, cyc == m_inv);
        chk("pulse_exp", core_reset_mod_exp, cyc == m_exp);
        chk("core_p", core_p, m_cp);
        chk("core_q", core_q, m_cq);
        chk("core_ed", core_encrypt_decrypt, m_ced);
        chk("core_msg_in", core_msg_in, m_cmsg);
        if (rv) begin
          chk("resp_msg", resp_msg, m_rmsg);
          chk("resp_error", resp_error, m_rerr);
        end
        if (jid >= 0 && jid < 12) begin
          if (core_reset_inverter && obs_inv[jid] < 0) obs_inv[jid] = cyc - m_t0;
          if (core_reset_mod_exp && obs_exp[jid] < 0)  obs_exp[jid] = cyc - m_t0;
          if (resp_valid && obs_resp[jid] < 0) begin
            obs_resp[jid] = cyc - m_t0;
            obs_msg[jid]  = resp_msg;
            obs_err[jid]  = resp_error;
          end
        end
      end
    end
  end

  task automatic do_async_reset();
    chk_en = 1'b0;
    #2;
    reset_n   = 1'b0;
    req_valid = 1'b0;
    #1;
    chk_reset_values("arst");
    m_t0 = -1; m_inv = -1; m_exp = -1; m_resp = -1; m_rel = -1;
    m_kv = 1'b0; m_cp = '0; m_cq = '0; m_ced = 1'b0; m_cmsg = '0;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk_en = 1'b1;
  endtask

  // Called one time unit after a rising edge with the sequencer idle.
  task automatic run_job(input logic [W-1:0] p, input logic [W-1:0] q, input logic ed,
                         input logic [2*W-1:0] msg, input int mode, input int hold,
                         input bit spam, input bit rr_early, input int abort_at);
    bit hit;
    int t0, a, b;
    stub_mode = mode;
    hit = m_kv && (p == m_kp) && (q == m_kq) && (ed == m_ked);
    t0  = cyc;
    req_p = p; req_q = q; req_encrypt_decrypt = ed; req_msg = msg; req_valid = 1'b1;
    jid++;
    m_t0 = t0;
    m_inv = hit ? -1 : t0 + 1;
    if (hit) m_exp = t0 + 1;
    else if (mode == M_NEVER) m_exp = -1;
    else begin
      a = (mode == M_STALE) ? m_inv + 2 : m_inv + 5;
      m_exp = a + 1;
    end
    if (m_exp >= 0) begin
      b = (mode == M_STALE) ? m_exp + 2 : m_exp + 8;
      m_resp = b + 1;
    end else begin
      m_resp = t0 + 2 + TO;
    end
    m_rel  = m_resp + hold;
    m_rmsg = (mode == M_NEVER) ? '0 : ~msg;
    m_rerr = (mode == M_NEVER);
    if (mode == M_NEVER) m_kv = 1'b0;
    else if (!hit) begin m_kv = 1'b1; m_kp = p; m_kq = q; m_ked = ed; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    m_cp = p; m_cq = q; m_ced = ed; m_cmsg = msg;
    while (cyc < m_rel) begin
      if (abort_at > 0 && cyc == t0 + abort_at) begin
        do_async_reset();
        stub_mode = M_NORMAL;
        return;
      end
      resp_ready = rr_early;
      if (spam) begin
        req_valid = 1'b1; req_p = 128'hdead; req_q = 128'hbeef; req_msg = 256'h1234;
      end
      @(posedge clk); #1;
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    stub_mode  = M_NORMAL;
  endtask

  initial begin
    logic [W-1:0]   p1, q1;
    logic [2*W-1:0] msg1, msg2;
    p1   = 128'd113680897410347;
    q1   = 128'd7999808077935876437321;
    msg1 = 256'h806a3e00000000000000000000;
    msg2 = 256'h3e18000000000000000000;
    #12;
    chk_reset_values("rst");
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk_en = 1'b1;
    repeat (2) begin @(posedge clk); #1; end

    run_job(p1, q1, 1'b0, msg1, M_NORMAL, 0, 1'b0, 1'b0, 0);       // 0: miss
    chk("j0_inv", obs_inv[0], 1);
    chk("j0_exp", obs_exp[0], 7);
    chk("j0_resp", obs_resp[0], 16);
    chk("j0_msg", obs_msg[0], ~msg1);
    chk("j0_err", obs_err[0], 0);

    run_job(p1, q1, 1'b0, msg2, M_NORMAL, 0, 1'b0, 1'b1, 0);       // 1: hit
    chk("j1_inv", obs_inv[1], -1);
    chk("j1_exp", obs_exp[1], 1);
    chk("j1_resp", obs_resp[1], 10);
    chk("j1_msg", obs_msg[1], ~msg2);

    run_job(q1, p1, 1'b0, msg1, M_NORMAL, 0, 1'b0, 1'b0, 0);       // 2: swapped
    chk("j2_inv", obs_inv[2], 1);
    run_job(p1, q1, 1'b1, msg2, M_NORMAL, 0, 1'b0, 1'b0, 0);       // 3: decrypt
    chk("j3_inv", obs_inv[3], 1);

    run_job(p1, q1, 1'b1, msg1, M_NORMAL, 20, 1'b1, 1'b0, 0);      // 4: backpressure
    chk("j4_inv", obs_inv[4], -1);
    chk("j4_resp", obs_resp[4], 10);
    chk("j4_idle_after", req_ready, 1);

    run_job(128'd5, 128'd7, 1'b0, msg1, M_NEVER, 0, 1'b0, 1'b0, 0); // 5: timeout
    chk("j5_resp", obs_resp[5], 18);
    chk("j5_err", obs_err[5], 1);
    chk("j5_msg", obs_msg[5], 0);
    run_job(128'd5, 128'd7, 1'b0, msg2, M_NORMAL, 0, 1'b0, 1'b0, 0); // 6: miss again
    chk("j6_inv", obs_inv[6], 1);

    run_job(128'd5, 128'd7, 1'b0, msg1, M_NORMAL, 0, 1'b0, 1'b0, 5); // 7: reset in EXP_WAIT
    chk("j7_exp", obs_exp[7], 1);
    run_job(128'd5, 128'd7, 1'b0, msg2, M_NORMAL, 0, 1'b0, 1'b0, 0); // 8: miss after reset
    chk("j8_inv", obs_inv[8], 1);

    run_job(128'd11, 128'd13, 1'b0, msg1, M_STALE, 0, 1'b0, 1'b0, 0); // 9: stale finish
    chk("j9_exp", obs_exp[9], 4);
    chk("j9_resp", obs_resp[9], 7);

    repeat (3) begin @(posedge clk); #1; end
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rsa_job_sequencer.md
Name: rsa_job_sequencer

Overview:
- Hardware initiator for the RSA `control` core. It replaces the bench-driven reset_inverter/reset_mod_exp pulse-and-wait sequence with an FSM.
- It accepts one job (p, q, encrypt_decrypt, msg) over a valid/ready request port and sequences the core's inverter phase, then its mod_exp phase.
- It returns msg_out over a valid/ready response port.
- It skips the inverter phase when the key matches the last completed one, and flags core hangs via a timeout.

Parameters:
- WIDTH, 128, prime width; message width is 2*WIDTH.
- TIMEOUT_CYCLES, 65535, maximum cycles a wait state may last before it aborts; must be >= 2.

Ports:
- clk  in  1  clock; all logic is on its rising edge
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  1  job offered
- req_ready  out  1  sequencer can accept a job
- req_p  in  WIDTH  prime p
- req_q  in  WIDTH  prime q
- req_encrypt_decrypt  in  1  0 = encrypt, 1 = decrypt
- req_msg  in  2*WIDTH  input message
- resp_valid  out  1  result available
- resp_ready  in  1  consumer takes result
- resp_msg  out  2*WIDTH  core msg_out, or 0 on error
- resp_error  out  1  job aborted by timeout
- busy  out  1  state != IDLE
- core_p  out  WIDTH  to control p
- core_q  out  WIDTH  to control q
- core_encrypt_decrypt  out  1  to control
- core_msg_in  out  2*WIDTH  to control msg_in
- core_reset_inverter  out  1  one-cycle start pulse, inverter
- core_reset_mod_exp  out  1  one-cycle start pulse, mod_exp
- core_inverter_finish  in  1  from control
- core_mod_exp_finish  in  1  from control
- core_msg_out  in  2*WIDTH  from control

Behaviour:
- Reset values:
  - State is IDLE.
  - All outputs are 0 except req_ready=1.
  - key_valid=0; timeout counter is 0.
- FSM states: IDLE, INV_PULSE, INV_WAIT, EXP_PULSE, EXP_WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, latch p, q, encrypt_decrypt and msg into the core_* registers.
  - These registers hold stable until the next accept.
  - Key hit (key_valid and latched p, q, encrypt_decrypt all equal the stored key) goes to EXP_PULSE; otherwise go to INV_PULSE.
- INV_PULSE: core_reset_inverter=1 for exactly one cycle; clear the counter; go to INV_WAIT.
- INV_WAIT:
  - The first cycle is blanked, so a stale finish is ignored.
  - From the second cycle, core_inverter_finish=1 stores the key, sets key_valid=1 and goes to EXP_PULSE.
- EXP_PULSE: core_reset_mod_exp=1 for exactly one cycle; clear the counter; go to EXP_WAIT.
- EXP_WAIT:
  - The first cycle is blanked.
  - After that, core_mod_exp_finish=1 registers core_msg_out into resp_msg with resp_error=0, and goes to RESP.
- Timeout:
  - The counter increments each cycle in either wait state.
  - Reaching TIMEOUT_CYCLES-1 without finish goes to RESP with resp_msg=0, resp_error=1 and key_valid=0.
- RESP:
  - resp_valid=1; resp_msg and resp_error are held stable.
  - On resp_ready, go to IDLE the next cycle.
  - resp_valid and req_ready are never high together.
- Latency, miss path: accept at cycle 0 gives pulse at 1, blank at 2, and finish sampled from 3.
  - Inverter finish at cycle a (a>=3) gives the mod_exp pulse at a+1.
  - Mod_exp finish at cycle b (b>=a+3) gives resp_valid at b+1.
  - Hit path: the mod_exp pulse is at cycle 1.
- Finish asserted during a pulse or blank cycle is ignored. A finish held high continuously is taken on the first unblanked cycle.
- Asynchronous reset mid-job:
  - Immediate return to reset values; any pulse in flight drops.
  - key_valid clears.
  - The core is not otherwise notified; the next job restarts the core with fresh pulses.
- req_valid while busy is ignored (req_ready=0). resp_ready outside RESP is ignored.

Decomposition:
- Shared package rsa_pkg: state enum, default WIDTH, default TIMEOUT_CYCLES.
- One natural sub-module, rsa_key_cache: registers stored p, q and encrypt_decrypt plus key_valid; outputs hit; has store and invalidate inputs.
- The FSM and timeout counter stay in the top.

Test Plan:
All scenarios use a stub core: inverter finish 5 cycles after its pulse, mod_exp finish 8 cycles after its pulse, msg_out = ~msg_in.
- Miss path: p=113680897410347, q=7999808077935876437321, encrypt_decrypt=0, msg=256'h806a3e00000000000000000000 accepted at cycle 0.
  - Inverter pulse at cycle 1; mod_exp pulse at 7.
  - resp_valid at 16 with resp_msg=~msg, resp_error=0.
- Key hit: repeat the same p, q and encrypt_decrypt with msg=256'h3e18000000000000000000.
  - No inverter pulse; mod_exp pulse at cycle 1; resp_valid at 10.
- Swapped key: p and q exchanged gives a miss, so an inverter pulse occurs. A decrypt with the same p and q also misses.
- Backpressure: hold resp_ready=0 for 20 cycles.
  - resp_valid and resp_msg stay stable; req_ready=0 and req_valid is ignored.
  - Release gives IDLE the next cycle.
- Timeout: stub never asserts inverter finish, TIMEOUT_CYCLES=16.
  - resp_error=1, resp_msg=0; the next identical job misses.
- Async reset: reset_n low during EXP_WAIT.
  - Outputs return to reset values immediately; req_ready=1; the next job takes the miss path.
- Stale finish: stub holds finish high into the pulse and blank cycles; the sequencer does not advance until the first unblanked cycle.
